// File: rtl/jet_infer_sched.sv
// jet_infer_sched: frame-level sequencer for the batch-norm jet-tagging core.
// Collects INPUT_SIZE signed feature words, pulses the core's reset and start,
// waits for core_output_ready plus a settle delay, captures the scores, picks
// the signed argmax and offers the result on a valid/ready stream. A watchdog
// drops the frame and raises a sticky err if the core never answers.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s_valid/s_ready/s_data    upstream feature stream, word 0 first
//   core_reset            active-high reset to the inference core
//   core_input_ready      one-cycle start pulse to the core
//   core_output_ready     core done
//   core_input_data       frame register, feature i at [i*WIDTH +: WIDTH]
//   core_output_data      core scores, same packing
//   m_valid/m_ready/m_data/m_class    result stream (scores + argmax index)
//   busy                  controller not idle in LOAD
//   err, err_clr          sticky timeout flag and its clear
//
// Optional build macro JET_SCHED_PERF_EN adds perf_frames (delivered frame
// count) and perf_latency (WAIT cycles of the last captured frame).

module jet_infer_sched #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned NFRAC         = 10,
    parameter int unsigned INPUT_SIZE    = 16,
    parameter int unsigned OUTPUT_SIZE   = 5,
    parameter int unsigned RST_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [WIDTH-1:0]                  s_data,
    output logic                              core_reset,
    output logic                              core_input_ready,
    input  logic                              core_output_ready,
    output logic [INPUT_SIZE*WIDTH-1:0]       core_input_data,
    input  logic [OUTPUT_SIZE*WIDTH-1:0]      core_output_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [OUTPUT_SIZE*WIDTH-1:0]      m_data,
    output logic [$clog2(OUTPUT_SIZE)-1:0]    m_class,
    output logic                              busy,
    output logic                              err,
`ifdef JET_SCHED_PERF_EN
    output logic [31:0]                       perf_frames,
    output logic [$clog2(TIMEOUT+1)-1:0]      perf_latency,
`endif
    input  logic                              err_clr
);

    localparam int unsigned IDX_W   = $clog2(INPUT_SIZE);
    localparam int unsigned CLS_W   = $clog2(OUTPUT_SIZE);
    localparam int unsigned LAT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned MAX_A   = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > SETTLE_CYCLES + 1) ? MAX_A : SETTLE_CYCLES + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FRM_W   = INPUT_SIZE * WIDTH;
    localparam int unsigned SCR_W   = OUTPUT_SIZE * WIDTH;

    // NFRAC only names the fixed-point format of the words passing through.
    if (NFRAC >= WIDTH || RST_CYCLES < 1 || TIMEOUT < 1) begin : g_param_range_unchecked
    end

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_WAIT     = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_OUT      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic               s_ready_q, s_ready_d;
    logic               core_reset_q, core_reset_d;
    logic               core_input_ready_q, core_input_ready_d;
    logic               m_valid_q, m_valid_d;
    logic [SCR_W-1:0]   m_data_q, m_data_d;
    logic [CLS_W-1:0]   m_class_q, m_class_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               err_set;

`ifdef JET_SCHED_PERF_EN
    logic [31:0]        perf_frames_q, perf_frames_d;
    logic [LAT_W-1:0]   perf_latency_q, perf_latency_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
`endif

    // Signed argmax over the live core scores; strict compare keeps the lowest index on ties.
    logic signed [WIDTH-1:0] best_val;
    logic [CLS_W-1:0]        best_idx;

    always_comb begin
        best_val = $signed(core_output_data[WIDTH-1:0]);
        best_idx = '0;
        for (int i = 1; i < OUTPUT_SIZE; i++) begin
            if ($signed(core_output_data[i*WIDTH +: WIDTH]) > best_val) begin
                best_val = $signed(core_output_data[i*WIDTH +: WIDTH]);
                best_idx = CLS_W'(i);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        idx_d              = idx_q;
        frame_d            = frame_q;
        s_ready_d          = s_ready_q;
        core_reset_d       = 1'b0;
        core_input_ready_d = 1'b0;
        m_valid_d          = m_valid_q;
        m_data_d           = m_data_q;
        m_class_d          = m_class_q;
        err_set            = 1'b0;
`ifdef JET_SCHED_PERF_EN
        perf_frames_d      = perf_frames_q;
        perf_latency_d     = perf_latency_q;
        lat_d              = lat_q;
`endif

        case (state_q)
            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    for (int i = 0; i < INPUT_SIZE; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            frame_d[i*WIDTH +: WIDTH] = s_data;
                        end
                    end
                    if (idx_q == IDX_W'(INPUT_SIZE - 1)) begin
                        idx_d        = '0;
                        cnt_d        = '0;
                        s_ready_d    = 1'b0;
                        core_reset_d = 1'b1;
                        state_d      = ST_CORE_RST;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            // core_reset was raised on entry, so RST_CYCLES-1 more cycles here.
            ST_CORE_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d              = '0;
                    core_input_ready_d = 1'b1;
                    state_d            = ST_LAUNCH;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    core_reset_d = 1'b1;
                end
            end

            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            // Done beats timeout when both land on the same cycle.
            ST_WAIT: begin
                if (core_output_ready) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
`ifdef JET_SCHED_PERF_EN
                    lat_d   = LAT_W'(cnt_q) + LAT_W'(1);
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d     = '0;
                    err_set   = 1'b1;
                    s_ready_d = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
                    cnt_d     = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = core_output_data;
                    m_class_d = best_idx;
                    state_d   = ST_OUT;
`ifdef JET_SCHED_PERF_EN
                    perf_latency_d = lat_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_OUT: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = ST_LOAD;
`ifdef JET_SCHED_PERF_EN
                    perf_frames_d = perf_frames_q + 32'd1;
`endif
                end
            end

            default: begin
                s_ready_d = 1'b1;
                state_d   = ST_LOAD;
            end
        endcase

        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != ST_LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_LOAD;
            cnt_q              <= '0;
            idx_q              <= '0;
            frame_q            <= '0;
            s_ready_q          <= 1'b1;
            core_reset_q       <= 1'b1;
            core_input_ready_q <= 1'b0;
            m_valid_q          <= 1'b0;
            m_data_q           <= '0;
            m_class_q          <= '0;
            busy_q             <= 1'b0;
            err_q              <= 1'b0;
`ifdef JET_SCHED_PERF_EN
            perf_frames_q      <= '0;
            perf_latency_q     <= '0;
            lat_q              <= '0;
`endif
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            idx_q              <= idx_d;
            frame_q            <= frame_d;
            s_ready_q          <= s_ready_d;
            core_reset_q       <= core_reset_d;
            core_input_ready_q <= core_input_ready_d;
            m_valid_q          <= m_valid_d;
            m_data_q           <= m_data_d;
            m_class_q          <= m_class_d;
            busy_q             <= busy_d;
            err_q              <= err_d;
`ifdef JET_SCHED_PERF_EN
            perf_frames_q      <= perf_frames_d;
            perf_latency_q     <= perf_latency_d;
            lat_q              <= lat_d;
`endif
        end
    end

    assign s_ready          = s_ready_q;
    assign core_reset       = core_reset_q;
    assign core_input_ready = core_input_ready_q;
    assign core_input_data  = frame_q;
    assign m_valid          = m_valid_q;
    assign m_data           = m_data_q;
    assign m_class          = m_class_q;
    assign busy             = busy_q;
    assign err              = err_q;
`ifdef JET_SCHED_PERF_EN
    assign perf_frames      = perf_frames_q;
    assign perf_latency     = perf_latency_q;
`endif

endmodule

// File: tb/tb_jet_infer_sched.sv
// Directed bench for jet_infer_sched (TIMEOUT shortened to 64). A negedge
// monitor pops expected results from a scoreboard on every m handshake; the
// main sequence plays the core's role and checks protocol timing.

module tb_jet_infer_sched;

    localparam int unsigned WIDTH         = 16;
    localparam int unsigned NFRAC         = 10;
    localparam int unsigned INPUT_SIZE    = 16;
    localparam int unsigned OUTPUT_SIZE   = 5;
    localparam int unsigned RST_CYCLES    = 2;
    localparam int unsigned SETTLE_CYCLES = 10;
    localparam int unsigned TIMEOUT       = 64;
    localparam int unsigned CLS_W         = $clog2(OUTPUT_SIZE);
    localparam int unsigned LAT_W         = $clog2(TIMEOUT + 1);
    localparam int unsigned RESP_DELAY    = 20;

    typedef struct packed {
        logic [OUTPUT_SIZE*WIDTH-1:0] data;
        logic [CLS_W-1:0]             cls;
    } exp_t;

    logic                           clk;
    logic                           reset_n;
    logic                           s_valid;
    logic                           s_ready;
    logic [WIDTH-1:0]               s_data;
    logic                           core_reset;
    logic                           core_input_ready;
    logic                           core_output_ready;
    logic [INPUT_SIZE*WIDTH-1:0]    core_input_data;
    logic [OUTPUT_SIZE*WIDTH-1:0]   core_output_data;
    logic                           m_valid;
    logic                           m_ready;
    logic [OUTPUT_SIZE*WIDTH-1:0]   m_data;
    logic [CLS_W-1:0]               m_class;
    logic                           busy;
    logic                           err;
    logic                           err_clr;
`ifdef JET_SCHED_PERF_EN
    logic [31:0]                    perf_frames;
    logic [LAT_W-1:0]               perf_latency;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int frame_a [INPUT_SIZE] = '{-304, 378, 253, -8, 123, 14, -399, -144,
                                 -399, -629, -664, -537, -586, -376, 284, 430};
    int score_tab [3][OUTPUT_SIZE] = '{'{100, -50, 900, 900, 3},
                                       '{-5, -3, -3, -100, -7},
                                       '{-1, -2, -3, -4, 7}};
    int exp_cls [3] = '{2, 1, 4};

    jet_infer_sched #(
        .WIDTH(WIDTH), .NFRAC(NFRAC), .INPUT_SIZE(INPUT_SIZE), .OUTPUT_SIZE(OUTPUT_SIZE),
        .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_reset(core_reset), .core_input_ready(core_input_ready),
        .core_output_ready(core_output_ready), .core_input_data(core_input_data),
        .core_output_data(core_output_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_class(m_class),
        .busy(busy), .err(err),
`ifdef JET_SCHED_PERF_EN
        .perf_frames(perf_frames), .perf_latency(perf_latency),
`endif
        .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word(input int sel, input int i);
        int w;
        w = (sel == 0) ? frame_a[i] : frame_a[INPUT_SIZE-1-i];
        return WIDTH'(w);
    endfunction

    function automatic logic [INPUT_SIZE*WIDTH-1:0] exp_frame(input int sel);
        logic [INPUT_SIZE*WIDTH-1:0] v;
        for (int i = 0; i < INPUT_SIZE; i++) v[i*WIDTH +: WIDTH] = word(sel, i);
        return v;
    endfunction

    function automatic logic [OUTPUT_SIZE*WIDTH-1:0] scores(input int sel);
        logic [OUTPUT_SIZE*WIDTH-1:0] v;
        for (int i = 0; i < OUTPUT_SIZE; i++) v[i*WIDTH +: WIDTH] = WIDTH'(score_tab[sel][i]);
        return v;
    endfunction

    // Scoreboard monitor: a handshake happens on the next posedge.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            check("sb_result_expected", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_m_data", 256'(m_data), 256'(e.data));
                check("sb_m_class", 256'(m_class), 256'(e.cls));
            end
        end
    end

    // Stream one frame; leaves time just after the edge that took the last word.
    task automatic send_frame(input int sel, input int gap);
        int n;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            n = 0;
            while (!s_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!s_ready) check("s_ready_wait", 256'(s_ready), 256'(1));
            s_valid = 1'b1;
            s_data  = word(sel, i);
            @(posedge clk); #1;
            s_valid = 1'b0;
            if (i != INPUT_SIZE - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // core_reset for RST_CYCLES cycles, then a single start pulse.
    task automatic check_launch(input int sel);
        logic [3:0] rs;
        logic [3:0] ir;
        rs = '0;
        ir = '0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin @(posedge clk); #1; end
            rs = {rs[2:0], core_reset};
            ir = {ir[2:0], core_input_ready};
        end
        check("core_reset_seq", 256'(rs), 256'(4'b1100));
        check("input_ready_seq", 256'(ir), 256'(4'b0010));
        check("core_input_data", 256'(core_input_data), 256'(exp_frame(sel)));
        check("busy_running", 256'(busy), 256'(1));
    endtask

    // Answer RESP_DELAY cycles after the start pulse and time m_valid.
    task automatic respond(input int ssel, input int fsel);
        int n;
        repeat (RESP_DELAY - 1) @(posedge clk);
        #1;
        core_output_data  = scores(ssel);
        core_output_ready = 1'b1;
        sb.push_back('{data: scores(ssel), cls: CLS_W'(exp_cls[ssel])});
        @(posedge clk); #1;
        core_output_ready = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("m_valid_latency", 256'(n), 256'(SETTLE_CYCLES + 1));
        check("frame_stable", 256'(core_input_data), 256'(exp_frame(fsel)));
    endtask

    task automatic after_handshake();
        @(posedge clk); #1;
        check("m_valid_dropped", 256'(m_valid), 256'(0));
        check("s_ready_back", 256'(s_ready), 256'(1));
    endtask

    initial begin
        int   n;
        bit   bad;
        bit   mv_seen;
        logic [OUTPUT_SIZE*WIDTH-1:0] hold_data;
        logic [CLS_W-1:0]             hold_cls;

        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; err_clr = 1'b0;
        core_output_ready = 1'b0; core_output_data = '0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("rst_ctrl", 256'({s_ready, core_reset, core_input_ready, m_valid, busy, err}), 256'(6'b110000));
        check("rst_data", 256'({m_class, m_data}), 256'(0));
        check("rst_frame", 256'(core_input_data), 256'(0));
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        check("core_reset_held", 256'(core_reset), 256'(1));
        @(posedge clk); #1;
        check("core_reset_release", 256'(core_reset), 256'(0));
        check("idle_after_reset", 256'({s_ready, busy}), 256'(2'b10));

        // Test 1: normal frame, no gaps
        send_frame(0, 0);
        check("word0", 256'(core_input_data[WIDTH-1:0]), 256'(16'hFED0));
        check_launch(0);
        respond(0, 0);
        after_handshake();

        // Test 2: bubbles between words
        send_frame(0, 3);
        check_launch(0);
        respond(0, 0);
        after_handshake();

        // Test 3: result backpressure, upstream attempts blocked
        m_ready = 1'b0;
        send_frame(1, 0);
        check_launch(1);
        respond(1, 1);
        hold_data = m_data;
        hold_cls  = m_class;
        check("bp_m_data", 256'(hold_data), 256'(scores(1)));
        check("bp_m_class", 256'(hold_cls), 256'(exp_cls[1]));
        bad = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        repeat (50) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b1 || m_data !== hold_data || m_class !== hold_cls || s_ready !== 1'b0)
                bad = 1'b1;
        end
        s_valid = 1'b0;
        check("bp_stable", 256'(bad), 256'(0));
        check("bp_frame_unchanged", 256'(core_input_data), 256'(exp_frame(1)));
        m_ready = 1'b1;
        after_handshake();
        send_frame(0, 0);
        check_launch(0);
        respond(0, 0);
        after_handshake();

        // Test 4: core never answers
        send_frame(0, 0);
        check_launch(0);
        n = 0;
        mv_seen = 1'b0;
        while (!err && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (m_valid) mv_seen = 1'b1;
        end
        check("timeout_cycles", 256'(n), 256'(TIMEOUT));
        check("timeout_idle", 256'({err, busy, s_ready, mv_seen}), 256'(4'b1010));
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 256'(err), 256'(1));
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_cleared", 256'(err), 256'(0));
        send_frame(1, 0);
        check_launch(1);
        respond(2, 1);
        after_handshake();

        // Test 5: reset pulse while waiting on the core
        send_frame(0, 0);
        check_launch(0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", 256'({s_ready, core_reset, core_input_ready, m_valid, busy, err}), 256'(6'b110000));
        check("midrst_data", 256'({m_class, m_data}), 256'(0));
        check("midrst_frame", 256'(core_input_data), 256'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        mv_seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (m_valid) mv_seen = 1'b1;
        end
        check("midrst_no_result", 256'(mv_seen), 256'(0));
        send_frame(0, 0);
        check_launch(0);
        respond(2, 0);
        after_handshake();
        send_frame(0, 0);
        check_launch(0);
        respond(0, 0);
        after_handshake();
`ifdef JET_SCHED_PERF_EN
        check("perf_frames", 256'(perf_frames), 256'(2));
        check("perf_latency", 256'(perf_latency), 256'(RESP_DELAY));
`endif

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 256'(sb.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
